// File: rtl/cmd_pkg.sv
// ============================================================================
// Module : cmd_pkg
// Brief  : Command codes, mode values, button indices and press-FSM state
//          shared by the input command encoder and its consumers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cmd_pkg;

    localparam logic [4:0] CMD_NONE             = 5'd0;
    localparam logic [4:0] CMD_MODE_NEXT        = 5'd1;
    localparam logic [4:0] CMD_RUN_TOGGLE       = 5'd2;  // reserved
    localparam logic [4:0] CMD_MODE_LOCAL_RESET = 5'd3;
    localparam logic [4:0] CMD_FMT_TOGGLE       = 5'd7;
    localparam logic [4:0] CMD_EDITMODE_TOGGLE  = 5'd8;
    localparam logic [4:0] CMD_EDITDIGIT_NEXT   = 5'd9;
    localparam logic [4:0] CMD_INC              = 5'd20;
    localparam logic [4:0] CMD_DEC              = 5'd21;

    localparam logic [1:0] MODE_WATCH     = 2'd0;
    localparam logic [1:0] MODE_STOPWATCH = 2'd1;
    localparam logic [1:0] MODE_ALARM     = 2'd2;

    localparam int BTN_C   = 0;
    localparam int BTN_L   = 1;
    localparam int BTN_R   = 2;
    localparam int BTN_U   = 3;
    localparam int BTN_D   = 4;
    localparam int NUM_BTN = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HELD     = 2'd1,
        LONGHELD = 2'd2
    } pressState_t;

    function automatic logic [4:0] shortCode(input int idx);
        case (idx)
            BTN_C:   shortCode = CMD_EDITMODE_TOGGLE;
            BTN_L:   shortCode = CMD_FMT_TOGGLE;
            BTN_R:   shortCode = CMD_EDITDIGIT_NEXT;
            BTN_U:   shortCode = CMD_INC;
            BTN_D:   shortCode = CMD_DEC;
            default: shortCode = CMD_NONE;
        endcase
    endfunction

    // U/D long codes double as auto-repeat codes; whether they fire is masked in the top.
    function automatic logic [4:0] longCode(input int idx);
        case (idx)
            BTN_C:   longCode = CMD_MODE_LOCAL_RESET;
            BTN_L:   longCode = CMD_MODE_NEXT;
            BTN_U:   longCode = CMD_INC;
            BTN_D:   longCode = CMD_DEC;
            default: longCode = CMD_NONE;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_press_fsm.sv
// ============================================================================
// Module : btn_press_fsm
// Brief  : Per-button edge detector and short/long press classifier with a
//          saturating hold counter; repeat counter when INPUT_CMD_AUTO_REPEAT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_press_fsm
    import cmd_pkg::*;
#(
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic iClk,
    input  logic iRstn,
    input  logic iTick,
    input  logic iBtn,
    output logic oShort,
    output logic oLong,
    output logic oRepeat
);

    localparam logic [15:0] c_LONG_MS = 16'(LONG_MS);

    pressState_t r_state, w_stateNext;
    logic        r_prevBtn;
    logic [15:0] r_holdCnt, w_holdCntNext, w_holdInc;
    logic        w_rise;

    assign w_rise    = iBtn & ~r_prevBtn;
    assign w_holdInc = (r_holdCnt == 16'hFFFF) ? r_holdCnt : r_holdCnt + 16'd1;

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            r_state   <= IDLE;
            r_holdCnt <= 16'd0;
            r_prevBtn <= 1'b1;  // a button held through reset must be released first
        end else begin
            r_state   <= w_stateNext;
            r_holdCnt <= w_holdCntNext;
            r_prevBtn <= iBtn;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_holdCntNext = r_holdCnt;
        oShort        = 1'b0;
        oLong         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_stateNext   = HELD;
                    w_holdCntNext = 16'd0;
                end
            end
            HELD: begin
                // release takes precedence over a coincident tick
                if (!iBtn) begin
                    oShort      = 1'b1;
                    w_stateNext = IDLE;
                end else if (iTick) begin
                    w_holdCntNext = w_holdInc;
                    if (w_holdInc == c_LONG_MS) begin
                        oLong       = 1'b1;
                        w_stateNext = LONGHELD;
                    end
                end
            end
            LONGHELD: begin
                if (!iBtn) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

`ifdef INPUT_CMD_AUTO_REPEAT_EN
    localparam logic [15:0] c_REPEAT_MS = 16'(REPEAT_MS);

    logic [15:0] r_repCnt;
    logic        w_repStep;

    assign w_repStep = (r_state == LONGHELD) && iBtn && iTick;
    assign oRepeat   = w_repStep && ((r_repCnt + 16'd1) == c_REPEAT_MS);

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            r_repCnt <= 16'd0;
        end else if (r_state != LONGHELD) begin
            r_repCnt <= 16'd0;
        end else if (w_repStep) begin
            r_repCnt <= oRepeat ? 16'd0 : r_repCnt + 16'd1;
        end
    end
`else
    assign oRepeat = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/input_cmd_encoder.sv
// ============================================================================
// Module : input_cmd_encoder
// Brief  : Five-button command encoder with pending flags, fixed-priority
//          arbiter and mode register. Option: INPUT_CMD_AUTO_REPEAT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module input_cmd_encoder
    import cmd_pkg::*;
#(
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200,
    parameter int NUM_MODES = 3
) (
    input  logic       iClk,
    input  logic       iRstn,
    input  logic       iTick1kHz,
    input  logic [4:0] iBtn,
    output logic [1:0] oMode,
    output logic       oCmdValid,
    output logic [4:0] oCmdCode
);

`ifdef INPUT_CMD_AUTO_REPEAT_EN
    localparam logic [4:0] c_LONG_MASK = 5'b11011;
`else
    localparam logic [4:0] c_LONG_MASK = 5'b00011;
`endif
    localparam logic [4:0] c_REPEAT_MASK = 5'b11000;
    localparam logic [1:0] c_LAST_MODE   = 2'(NUM_MODES - 1);

    logic [4:0] w_short, w_long, w_repeat, w_evValid;
    logic [4:0] w_evCode   [NUM_BTN];
    logic [4:0] w_pend;
    logic [4:0] w_pendCode [NUM_BTN];
    logic [4:0] w_selOneHot;
    logic       w_selValid;
    logic [4:0] w_selCode;

    logic [4:0] r_pend;
    logic [4:0] r_pendCode [NUM_BTN];
    logic       r_cmdValid;
    logic [4:0] r_cmdCode;
    logic [1:0] r_mode;

    generate
        for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
            btn_press_fsm #(
                .LONG_MS   (LONG_MS),
                .REPEAT_MS (REPEAT_MS)
            ) u_fsm (
                .iClk    (iClk),
                .iRstn   (iRstn),
                .iTick   (iTick1kHz),
                .iBtn    (iBtn[i]),
                .oShort  (w_short[i]),
                .oLong   (w_long[i]),
                .oRepeat (w_repeat[i])
            );
        end
    endgenerate

    assign w_evValid = w_short | (w_long & c_LONG_MASK) | (w_repeat & c_REPEAT_MASK);

    // Fresh events join the pending set in the same cycle so an idle arbiter
    // emits them on the very next edge.
    always_comb begin
        w_selValid  = 1'b0;
        w_selCode   = CMD_NONE;
        w_selOneHot = 5'b00000;
        for (int i = 0; i < NUM_BTN; i++) begin
            w_evCode[i]   = w_long[i] ? longCode(i) : shortCode(i);
            w_pend[i]     = r_pend[i] | w_evValid[i];
            w_pendCode[i] = w_evValid[i] ? w_evCode[i] : r_pendCode[i];
        end
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_selValid  = 1'b1;
                w_selCode   = w_pendCode[i];
                w_selOneHot = 5'b00001 << i;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            r_pend     <= 5'b00000;
            r_cmdValid <= 1'b0;
            r_cmdCode  <= CMD_NONE;
            r_mode     <= MODE_WATCH;
            for (int i = 0; i < NUM_BTN; i++) begin
                r_pendCode[i] <= CMD_NONE;
            end
        end else begin
            r_pend     <= w_pend & ~w_selOneHot;
            r_cmdValid <= w_selValid;
            r_cmdCode  <= w_selValid ? w_selCode : CMD_NONE;
            for (int i = 0; i < NUM_BTN; i++) begin
                r_pendCode[i] <= w_pendCode[i];
            end
            if (w_selValid && (w_selCode == CMD_MODE_NEXT)) begin
                r_mode <= (r_mode == c_LAST_MODE) ? 2'd0 : r_mode + 2'd1;
            end
        end
    end

    assign oMode     = r_mode;
    assign oCmdValid = r_cmdValid;
    assign oCmdCode  = r_cmdCode;

endmodule

`default_nettype wire

// File: tb/tb_input_cmd_encoder.sv
// ============================================================================
// Module : tb_input_cmd_encoder
// Brief  : Directed, table-driven self-checking bench for input_cmd_encoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_input_cmd_encoder;
    import cmd_pkg::*;

    logic       iClk = 1'b0;
    logic       iRstn = 1'b0;
    logic       iTick1kHz = 1'b0;
    logic [4:0] iBtn = 5'b00000;
    logic [1:0] oMode;
    logic       oCmdValid;
    logic [4:0] oCmdCode;

    input_cmd_encoder #(
        .LONG_MS   (1000),
        .REPEAT_MS (200),
        .NUM_MODES (3)
    ) dut (
        .iClk      (iClk),
        .iRstn     (iRstn),
        .iTick1kHz (iTick1kHz),
        .iBtn      (iBtn),
        .oMode     (oMode),
        .oCmdValid (oCmdValid),
        .oCmdCode  (oCmdCode)
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int tick1000Cyc = -1;
    int relCyc = 0;

    int capCode[$];
    int capCyc[$];
    int capMode[$];
    int capPrevMode[$];
    logic [1:0] lastMode = 2'd0;

    always @(posedge iClk) cyc <= cyc + 1;

    always @(negedge iClk) begin
        if (oCmdValid === 1'b1) begin
            capCode.push_back(int'(oCmdCode));
            capCyc.push_back(cyc);
            capMode.push_back(int'(oMode));
            capPrevMode.push_back(int'(lastMode));
        end
        lastMode = oMode;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [4:0] btn;
        int         ticks;
        int         n;
        int         codes[5];
        int         spacing;  // >0: required cycle gap between successive pulses
        bit         relLat;   // 1: first pulse exactly one cycle after release
        string      name;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs[NVEC];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic holdTicks(input int n);
        for (int k = 0; k < n; k++) begin
            iTick1kHz = 1'b1;
            if (k == 999) tick1000Cyc = cyc;
            step();
            iTick1kHz = 1'b0;
            step();
        end
    endtask

    task automatic clearCap();
        capCode.delete();
        capCyc.delete();
        capMode.delete();
        capPrevMode.delete();
    endtask

    task automatic runVec(input vec_t v);
        clearCap();
        iBtn = v.btn;
        step();
        holdTicks(v.ticks);
        iBtn = 5'b00000;
        relCyc = cyc;
        repeat (12) step();
        chk($sformatf("%s_count", v.name), capCode.size(), v.n);
        for (int k = 0; k < v.n; k++) begin
            chk($sformatf("%s_code%0d", v.name, k), qget(capCode, k), v.codes[k]);
            if (k > 0 && v.spacing > 0)
                chk($sformatf("%s_gap%0d", v.name, k),
                    qget(capCyc, k) - qget(capCyc, k - 1), v.spacing);
        end
        if (v.relLat && v.n > 0)
            chk($sformatf("%s_latency", v.name), qget(capCyc, 0), relCyc + 1);
    endtask

    initial begin
        vecs[0]  = '{5'b00001,  300, 1, '{8, 0, 0, 0, 0},    0, 1'b1, "C_short300"};
        vecs[1]  = '{5'b00001,  999, 1, '{8, 0, 0, 0, 0},    0, 1'b1, "C_short999"};
        vecs[2]  = '{5'b00001, 1000, 1, '{3, 0, 0, 0, 0},    0, 1'b0, "C_long1000"};
        vecs[3]  = '{5'b00010,   10, 1, '{7, 0, 0, 0, 0},    0, 1'b1, "L_short"};
        vecs[4]  = '{5'b00100,    5, 1, '{9, 0, 0, 0, 0},    0, 1'b1, "R_short"};
        vecs[5]  = '{5'b00100, 1200, 0, '{0, 0, 0, 0, 0},    0, 1'b0, "R_long"};
        vecs[6]  = '{5'b01000,   50, 1, '{20, 0, 0, 0, 0},   0, 1'b1, "U_short"};
        vecs[7]  = '{5'b10000,    1, 1, '{21, 0, 0, 0, 0},   0, 1'b1, "D_short1"};
        vecs[8]  = '{5'b10000,    0, 1, '{21, 0, 0, 0, 0},   0, 1'b1, "D_short0"};
        vecs[9]  = '{5'b10101,    5, 3, '{8, 9, 21, 0, 0},   1, 1'b1, "CRD_same"};
        vecs[10] = '{5'b11111,    3, 5, '{8, 7, 9, 20, 21},  1, 1'b1, "All_same"};
        vecs[11] = '{5'b10000,  999, 1, '{21, 0, 0, 0, 0},   0, 1'b1, "D_short999"};
`ifdef INPUT_CMD_AUTO_REPEAT_EN
        vecs[12] = '{5'b01000, 1650, 4, '{20, 20, 20, 20, 0}, 400, 1'b0, "U_repeat"};
        vecs[13] = '{5'b10000, 1000, 1, '{21, 0, 0, 0, 0},   0, 1'b0, "D_long"};
`else
        vecs[12] = '{5'b01000, 1650, 0, '{0, 0, 0, 0, 0},    0, 1'b0, "U_repeat"};
        vecs[13] = '{5'b10000, 1000, 0, '{0, 0, 0, 0, 0},    0, 1'b0, "D_long"};
`endif

        // Reset state with U held through reset deassertion
        iBtn = 5'b01000;
        repeat (3) step();
        chk("rst_mode", int'(oMode), 0);
        chk("rst_valid", int'(oCmdValid), 0);
        chk("rst_code", int'(oCmdCode), 0);
        clearCap();
        iRstn = 1'b1;
        step();
        holdTicks(50);
        iBtn = 5'b00000;
        repeat (12) step();
        chk("rst_held_count", capCode.size(), 0);
        clearCap();
        iBtn = 5'b01000;
        step();
        holdTicks(50);
        iBtn = 5'b00000;
        relCyc = cyc;
        repeat (12) step();
        chk("rst_repress_count", capCode.size(), 1);
        chk("rst_repress_code", qget(capCode, 0), 20);
        chk("rst_repress_latency", qget(capCyc, 0), relCyc + 1);

        // C long: one pulse right after the 1000th tick, nothing on release
        clearCap();
        iBtn = 5'b00001;
        step();
        holdTicks(1200);
        iBtn = 5'b00000;
        repeat (12) step();
        chk("C_long1200_count", capCode.size(), 1);
        chk("C_long1200_code", qget(capCode, 0), 3);
        chk("C_long1200_time", qget(capCyc, 0), tick1000Cyc + 1);

        for (int i = 0; i < NVEC; i++) runVec(vecs[i]);

        // L long three times walks the mode ring
        for (int m = 0; m < 3; m++) begin
            clearCap();
            iBtn = 5'b00010;
            step();
            holdTicks(1000);
            repeat (5) step();
            iBtn = 5'b00000;
            repeat (8) step();
            chk($sformatf("mode%0d_count", m), capCode.size(), 1);
            chk($sformatf("mode%0d_code", m), qget(capCode, 0), 1);
            chk($sformatf("mode%0d_time", m), qget(capCyc, 0), tick1000Cyc + 1);
            chk($sformatf("mode%0d_new", m), qget(capMode, 0), (m + 1) % 3);
            chk($sformatf("mode%0d_prev", m), qget(capPrevMode, 0), m);
            chk($sformatf("mode%0d_hold", m), int'(oMode), (m + 1) % 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
